// File: rtl/prio_encoder_queue.sv
// prio_encoder_queue: captures request events into a pending register and
// offers the highest-priority unmasked pending bit as a binary index over a
// valid/ready handshake. The accepted bit is cleared when it is consumed.
module prio_encoder_queue #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned IDX_W     = $clog2(WIDTH),
   parameter int unsigned MSB_FIRST = 1,
   parameter int unsigned EDGE      = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] req_in,
   input  logic [WIDTH-1:0] mask,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] pending,
   output logic [IDX_W:0]   pend_cnt,
   output logic             drop_o
);

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [WIDTH-1:0] req_q;
   logic [IDX_W:0]   cnt_q, cnt_d;
   logic             drop_q, drop_d;

   logic             accept;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] cap;
   logic [WIDTH-1:0] elig;
   logic [IDX_W-1:0] sel;

   // Capture, clear and drop detection for the pending register.
   always_comb begin
      accept = (state_q == OFFER) && out_ready;
      clr    = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         clr[i] = accept && (idx_q == IDX_W'(i));
      end
      cap       = (EDGE != 0) ? (req_in & ~req_q) : req_in;
      // Set wins over clear on the same bit.
      pending_d = (pending_q & ~clr) | cap;
      drop_d    = (EDGE != 0) && (|(cap & pending_q & ~clr));
      cnt_d     = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cnt_d = cnt_d + {{IDX_W{1'b0}}, pending_d[i]};
      end
   end

   // Priority selection over eligible bits; the accepted bit is excluded.
   always_comb begin
      elig = pending_q & mask & ~clr;
      sel  = '0;
      if (MSB_FIRST != 0) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (elig[i]) sel = IDX_W'(i);
         end
      end else begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (elig[WIDTH-1-i]) sel = IDX_W'(WIDTH-1-i);
         end
      end
   end

   // Offer FSM next state: hold the offer until accepted, reload on accept.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (elig != '0) begin
               idx_d   = sel;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (accept) begin
               if (elig != '0) begin
                  idx_d = sel;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, index, pending, edge history, count and drop registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         pending_q <= '0;
         req_q     <= '0;
         cnt_q     <= '0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         req_q     <= req_in;
         cnt_q     <= cnt_d;
         drop_q    <= drop_d;
      end
   end

   assign out_valid = (state_q == OFFER);
   assign out_idx   = idx_q;
   assign pending   = pending_q;
   assign pend_cnt  = cnt_q;
   assign drop_o    = drop_q;

endmodule

// File: tb/tb_prio_encoder_queue.sv
// Directed bench for prio_encoder_queue: one MSB-first instance and one
// LSB-first instance, with hand-computed expectations at each step.
module tb_prio_encoder_queue;

   logic       clk;
   logic       rst;
   logic [7:0] req, mask;
   logic       rdy;
   logic [2:0] idx;
   logic       vld;
   logic [7:0] pend;
   logic [3:0] cnt;
   logic       drop;

   logic [7:0] req_l, mask_l;
   logic       rdy_l;
   logic [2:0] idx_l;
   logic       vld_l;
   logic [7:0] pend_l;
   logic [3:0] cnt_l;
   logic       drop_l;

   int checks = 0;
   int errors = 0;

   prio_encoder_queue #(.WIDTH(8), .MSB_FIRST(1), .EDGE(1)) dut (
      .clk(clk), .rst(rst), .req_in(req), .mask(mask),
      .out_idx(idx), .out_valid(vld), .out_ready(rdy),
      .pending(pend), .pend_cnt(cnt), .drop_o(drop)
   );

   prio_encoder_queue #(.WIDTH(8), .MSB_FIRST(0), .EDGE(1)) dut_l (
      .clk(clk), .rst(rst), .req_in(req_l), .mask(mask_l),
      .out_idx(idx_l), .out_valid(vld_l), .out_ready(rdy_l),
      .pending(pend_l), .pend_cnt(cnt_l), .drop_o(drop_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; req = '0; mask = 8'hFF; rdy = 1'b1;
      req_l = '0; mask_l = 8'hFF; rdy_l = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("rst_valid", vld, 0);
      check("rst_pend",  pend, 0);
      check("rst_cnt",   cnt, 0);
      check("rst_idx",   idx, 0);
      check("rst_drop",  drop, 0);
      tick(); tick();
      rst = 1'b0;

      // Basic MSB-first ordering
      req = 8'h24; tick(); req = '0;
      check("t1_pend", pend, 8'h24);
      check("t1_nvld", vld, 0);
      tick();
      check("t1_vld5", vld, 1);
      check("t1_idx5", idx, 5);
      check("t1_cnt2", cnt, 2);
      tick();
      check("t1_idx2", idx, 2);
      check("t1_cnt1", cnt, 1);
      tick();
      check("t1_idle", vld, 0);
      check("t1_cnt0", cnt, 0);

      // Stall: no pre-emption by a higher-priority arrival
      rdy = 1'b0;
      req = 8'h01; tick(); req = '0; tick();
      check("t2_idx0", idx, 0);
      check("t2_vld",  vld, 1);
      req = 8'h80; tick(); req = '0;
      check("t2_hold", idx, 0);
      check("t2_pend", pend, 8'h81);
      tick();
      check("t2_hold2", idx, 0);
      rdy = 1'b1; tick();
      check("t2_idx7", idx, 7);
      check("t2_vld7", vld, 1);
      check("t2_pend7", pend, 8'h80);
      tick();
      check("t2_idle", vld, 0);
      check("t2_pend0", pend, 0);

      // LSB-first instance
      req_l = 8'h24; tick(); req_l = '0; tick();
      check("t3_vld", vld_l, 1);
      check("t3_idx2", idx_l, 2);
      tick();
      check("t3_idx5", idx_l, 5);
      tick();
      check("t3_idle", vld_l, 0);

      // Masked bits stay pending but are not offered
      mask = 8'hF0;
      req = 8'h0F; tick(); req = '0; tick();
      check("t4_nvld", vld, 0);
      check("t4_cnt4", cnt, 4);
      mask = 8'hFF; tick();
      check("t4_idx3", idx, 3);
      tick(); check("t4_idx2", idx, 2);
      tick(); check("t4_idx1", idx, 1);
      tick(); check("t4_idx0", idx, 0);
      tick(); check("t4_idle", vld, 0);

      // Drop on re-hit of a pending bit; accept-with-set keeps the bit
      rdy = 1'b0;
      req = 8'h08; tick(); req = '0; tick();
      check("t5_idx3", idx, 3);
      req = 8'h08; tick(); req = '0;
      check("t5_drop", drop, 1);
      check("t5_cnt1", cnt, 1);
      check("t5_pend", pend, 8'h08);
      tick();
      check("t5_drop_end", drop, 0);
      req = 8'h08; rdy = 1'b1; tick(); req = '0;
      check("t5_keep", pend, 8'h08);
      check("t5_nodrop", drop, 0);
      check("t5_gap", vld, 0);
      tick();
      check("t5_reoffer", vld, 1);
      check("t5_reidx", idx, 3);
      tick();
      check("t5_idle", vld, 0);
      check("t5_pend0", pend, 0);

      // Full pending, drop at full, async reset mid-offer
      rdy = 1'b0;
      req = 8'hFF; tick(); req = '0; tick();
      check("t6_vld", vld, 1);
      check("t6_cnt8", cnt, 8);
      check("t6_idx7", idx, 7);
      req = 8'h01; tick(); req = '0;
      check("t6_fulldrop", drop, 1);
      check("t6_fullcnt", cnt, 8);
      tick();
      req = 8'h01;
      #2 rst = 1'b1;
      #1;
      check("t6_rvld", vld, 0);
      check("t6_rpend", pend, 0);
      check("t6_rcnt", cnt, 0);
      tick();
      rst = 1'b0;
      rdy = 1'b1;
      tick();
      check("t6_e1_pend", pend, 8'h01);
      check("t6_e1_nvld", vld, 0);
      tick();
      check("t6_e2_vld", vld, 1);
      check("t6_e2_idx", idx, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
